// File: rtl/imm_gen_pkg.sv
// Shared types for the immediate generator: format codes, RV opcodes, skid states.
// LUI/AUIPC decoding is enabled by defining IMM_GEN_UTYPE_EN.
package imm_gen_pkg;

   typedef enum logic [2:0] {
      FMT_NONE  = 3'd0,
      FMT_I     = 3'd1,
      FMT_S     = 3'd2,
      FMT_B     = 3'd3,
      FMT_U     = 3'd4,
      FMT_J     = 3'd5,
      FMT_SHAMT = 3'd6
   } imm_fmt_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_IMM32  = 7'b0011011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [2:0] F3_SLL = 3'b001;
   localparam logic [2:0] F3_SRX = 3'b101;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } skid_state_t;

   function automatic logic is_shift(input logic [2:0] funct3);
      return (funct3 == F3_SLL) || (funct3 == F3_SRX);
   endfunction

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// Combinational RV32I/RV64I immediate decoder: inst_code -> {imm, fmt}.
// LUI/AUIPC are recognised only when IMM_GEN_UTYPE_EN is defined.
module imm_decode
   import imm_gen_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     inst_code,
   output logic [XLEN-1:0] imm,
   output imm_fmt_t        fmt
);

   logic [31:0] imm32;
   logic [2:0]  funct3;
   logic        sgn;

   assign funct3 = inst_code[14:12];
   assign sgn    = inst_code[31];

   always_comb begin
      imm32 = '0;
      fmt   = FMT_NONE;
      case (inst_code[6:0])
         OP_LOAD, OP_JALR: begin
            fmt   = FMT_I;
            imm32 = {{20{sgn}}, inst_code[31:20]};
         end
         OP_IMM: begin
            if (is_shift(funct3)) begin
               // inst[30] selects SRAI vs SRLI and must never reach the shift amount
               fmt   = FMT_SHAMT;
               imm32 = (XLEN == 64) ? {26'b0, inst_code[25:20]} : {27'b0, inst_code[24:20]};
            end else begin
               fmt   = FMT_I;
               imm32 = {{20{sgn}}, inst_code[31:20]};
            end
         end
         OP_IMM32: begin
            if (XLEN == 64) begin
               if (is_shift(funct3)) begin
                  fmt   = FMT_SHAMT;
                  imm32 = {27'b0, inst_code[24:20]};
               end else begin
                  fmt   = FMT_I;
                  imm32 = {{20{sgn}}, inst_code[31:20]};
               end
            end
         end
         OP_STORE: begin
            fmt   = FMT_S;
            imm32 = {{20{sgn}}, inst_code[31:25], inst_code[11:7]};
         end
         OP_BRANCH: begin
            fmt   = FMT_B;
            imm32 = {{19{sgn}}, sgn, inst_code[7], inst_code[30:25], inst_code[11:8], 1'b0};
         end
         OP_JAL: begin
            fmt   = FMT_J;
            imm32 = {{11{sgn}}, sgn, inst_code[19:12], inst_code[20], inst_code[30:21], 1'b0};
         end
`ifdef IMM_GEN_UTYPE_EN
         OP_LUI, OP_AUIPC: begin
            fmt   = FMT_U;
            imm32 = {inst_code[31:12], 12'b0};
         end
`endif
         default: begin
            fmt   = FMT_NONE;
            imm32 = '0;
         end
      endcase
   end

   // shift amounts carry a zero MSB, so a uniform sign extension is safe
   assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decoder, two-entry output skid, illegal-opcode counter.
// Define IMM_GEN_UTYPE_EN to decode LUI/AUIPC as U-format instead of illegal.
//
// state    | meaning
// ST_EMPTY | no result held, out_valid=0
// ST_ONE   | main register holds a result
// ST_FULL  | main and skid both hold results, in_ready=0
module imm_gen_pipe
   import imm_gen_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      inst_code,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  imm_out,
   output imm_fmt_t         fmt_out,
   output logic [TAG_W-1:0] tag_out,
   output logic [CNT_W-1:0] illegal_cnt
);

   logic [XLEN-1:0]  dec_imm;
   imm_fmt_t         dec_fmt;

   skid_state_t      state_q, state_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic [XLEN-1:0]  main_imm_q, main_imm_d, skid_imm_q, skid_imm_d;
   imm_fmt_t         main_fmt_q, main_fmt_d, skid_fmt_q, skid_fmt_d;
   logic [TAG_W-1:0] main_tag_q, main_tag_d, skid_tag_q, skid_tag_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             accept, drain;

   imm_decode #(.XLEN(XLEN)) u_decode (
      .inst_code (inst_code),
      .imm       (dec_imm),
      .fmt       (dec_fmt)
   );

   // a flush-cycle offer is neither stored nor counted
   assign accept = in_valid & in_ready_q & ~flush;
   assign drain  = out_valid_q & out_ready;

   always_comb begin
      state_d    = state_q;
      main_imm_d = main_imm_q;
      main_fmt_d = main_fmt_q;
      main_tag_d = main_tag_q;
      skid_imm_d = skid_imm_q;
      skid_fmt_d = skid_fmt_q;
      skid_tag_d = skid_tag_q;
      cnt_d      = cnt_q;
      case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               main_imm_d = dec_imm;
               main_fmt_d = dec_fmt;
               main_tag_d = in_tag;
               state_d    = ST_ONE;
            end
         end
         ST_ONE: begin
            if (accept && !drain) begin
               skid_imm_d = dec_imm;
               skid_fmt_d = dec_fmt;
               skid_tag_d = in_tag;
               state_d    = ST_FULL;
            end else if (accept && drain) begin
               main_imm_d = dec_imm;
               main_fmt_d = dec_fmt;
               main_tag_d = in_tag;
            end else if (drain) begin
               state_d = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (drain) begin
               main_imm_d = skid_imm_q;
               main_fmt_d = skid_fmt_q;
               main_tag_d = skid_tag_q;
               state_d    = ST_ONE;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
      if (flush) begin
         state_d = ST_EMPTY;
      end
      if (accept && (dec_fmt == FMT_NONE) && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      in_ready_d  = (state_d != ST_FULL);
      out_valid_d = (state_d != ST_EMPTY);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_EMPTY;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         main_imm_q  <= '0;
         main_fmt_q  <= FMT_NONE;
         main_tag_q  <= '0;
         skid_imm_q  <= '0;
         skid_fmt_q  <= FMT_NONE;
         skid_tag_q  <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         main_imm_q  <= main_imm_d;
         main_fmt_q  <= main_fmt_d;
         main_tag_q  <= main_tag_d;
         skid_imm_q  <= skid_imm_d;
         skid_fmt_q  <= skid_fmt_d;
         skid_tag_q  <= skid_tag_d;
         cnt_q       <= cnt_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign imm_out     = main_imm_q;
   assign fmt_out     = main_fmt_q;
   assign tag_out     = main_tag_q;
   assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 (narrow counter) instances driven in lockstep.
// Honours IMM_GEN_UTYPE_EN in its expectations.
module tb_imm_gen_pipe;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, out_ready;
   logic [31:0] inst_code;
   logic [4:0]  in_tag;

   logic        rdy32, vld32, rdy64, vld64;
   logic [31:0] imm32;
   logic [63:0] imm64;
   logic [2:0]  fmt32, fmt64;
   logic [4:0]  tag32, tag64;
   logic [15:0] cnt32;
   logic [3:0]  cnt64;

   localparam int CNT64_MAX = 15;
   localparam int CNT32_MAX = 65535;

   always #5 clk = ~clk;

   imm_gen_pipe #(.XLEN(32), .TAG_W(5), .CNT_W(16)) dut32 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
      .inst_code(inst_code), .in_tag(in_tag), .out_valid(vld32), .out_ready(out_ready),
      .imm_out(imm32), .fmt_out(fmt32), .tag_out(tag32), .illegal_cnt(cnt32)
   );

   imm_gen_pipe #(.XLEN(64), .TAG_W(5), .CNT_W(4)) dut64 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
      .inst_code(inst_code), .in_tag(in_tag), .out_valid(vld64), .out_ready(out_ready),
      .imm_out(imm64), .fmt_out(fmt64), .tag_out(tag64), .illegal_cnt(cnt64)
   );

   int vectors = 0;
   int miscompares = 0;
   int exp_cnt32 = 0;
   int exp_cnt64 = 0;

   typedef struct {
      logic [31:0] inst;
      logic [4:0]  tag;
      logic [63:0] imm32;
      logic [2:0]  fmt32;
      logic [63:0] imm64;
      logic [2:0]  fmt64;
   } vec_t;

   vec_t tbl[$];
   vec_t model_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_hs(input string name, input bit valid, input bit ready);
      chk({name, " out_valid32"}, 64'(vld32), 64'(valid));
      chk({name, " in_ready32"},  64'(rdy32), 64'(ready));
      chk({name, " out_valid64"}, 64'(vld64), 64'(valid));
      chk({name, " in_ready64"},  64'(rdy64), 64'(ready));
   endtask

   task automatic chk_data(input string name, input vec_t e);
      chk({name, " imm32"}, {32'b0, imm32}, e.imm32);
      chk({name, " fmt32"}, 64'(fmt32), 64'(e.fmt32));
      chk({name, " tag32"}, 64'(tag32), 64'(e.tag));
      chk({name, " imm64"}, imm64, e.imm64);
      chk({name, " fmt64"}, 64'(fmt64), 64'(e.fmt64));
      chk({name, " tag64"}, 64'(tag64), 64'(e.tag));
   endtask

   task automatic chk_cnt(input string name);
      chk({name, " cnt32"}, 64'(cnt32), 64'(exp_cnt32));
      chk({name, " cnt64"}, 64'(cnt64), 64'(exp_cnt64));
   endtask

   function automatic longint sx(input longint raw, input int bits);
      return (raw >= (longint'(1) << (bits - 1))) ? raw - (longint'(1) << bits) : raw;
   endfunction

   // reference decode from the format rules, using signed arithmetic on field values
   function automatic void ref_decode(input logic [31:0] ic, input bit is64,
                                      output logic [63:0] imm, output logic [2:0] fmt);
      longint v;
      bit     shift;
      v     = 0;
      fmt   = 3'd0;
      shift = (ic[14:12] == 3'd1) || (ic[14:12] == 3'd5);
      case (ic[6:0])
         7'b0000011, 7'b1100111: begin fmt = 3'd1; v = sx(longint'(ic[31:20]), 12); end
         7'b0010011: begin
            if (shift) begin fmt = 3'd6; v = is64 ? longint'(ic[25:20]) : longint'(ic[24:20]); end
            else begin fmt = 3'd1; v = sx(longint'(ic[31:20]), 12); end
         end
         7'b0011011: begin
            if (is64 && shift) begin fmt = 3'd6; v = longint'(ic[24:20]); end
            else if (is64) begin fmt = 3'd1; v = sx(longint'(ic[31:20]), 12); end
         end
         7'b0100011: begin
            fmt = 3'd2;
            v = sx(longint'(ic[31:25]) * 32 + longint'(ic[11:7]), 12);
         end
         7'b1100011: begin
            fmt = 3'd3;
            v = sx(longint'(ic[31]) * 4096 + longint'(ic[7]) * 2048
                   + longint'(ic[30:25]) * 32 + longint'(ic[11:8]) * 2, 13);
         end
         7'b1101111: begin
            fmt = 3'd5;
            v = sx(longint'(ic[31]) * 1048576 + longint'(ic[19:12]) * 4096
                   + longint'(ic[20]) * 2048 + longint'(ic[30:21]) * 2, 21);
         end
`ifdef IMM_GEN_UTYPE_EN
         7'b0110111, 7'b0010111: begin fmt = 3'd4; v = sx(longint'(ic[31:12]), 20) * 4096; end
`endif
         default: begin fmt = 3'd0; v = 0; end
      endcase
      imm = is64 ? 64'(v) : {32'b0, 32'(v)};
   endfunction

   function automatic void bump(input logic [2:0] f32, input logic [2:0] f64);
      if (f32 == 3'd0 && exp_cnt32 < CNT32_MAX) exp_cnt32++;
      if (f64 == 3'd0 && exp_cnt64 < CNT64_MAX) exp_cnt64++;
   endfunction

   function automatic logic [31:0] rand_inst();
      logic [31:0] r;
      logic [6:0]  ops [12];
      ops = '{7'b0000011, 7'b1100111, 7'b0010011, 7'b0011011, 7'b0100011, 7'b1100011,
              7'b1101111, 7'b0110111, 7'b0010111, 7'b0110011, 7'b1111111, 7'b0010011};
      r = $urandom();
      if (r[3:0] == 4'hF) return r;
      return {r[31:7], ops[$urandom_range(11, 0)]};
   endfunction

   vec_t e;
   logic [31:0] r;

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      inst_code = '0; in_tag = '0;

      tbl.push_back('{32'hFFF00093, 5'd1,  64'hFFFFFFFF, 3'd1, 64'hFFFFFFFFFFFFFFFF, 3'd1});
      tbl.push_back('{32'h01F09093, 5'd2,  64'h1F,       3'd6, 64'h1F,               3'd6});
      tbl.push_back('{32'h40F0D093, 5'd3,  64'h0F,       3'd6, 64'h0F,               3'd6});
      tbl.push_back('{32'hFE000EE3, 5'd4,  64'hFFFFFFFC, 3'd3, 64'hFFFFFFFFFFFFFFFC, 3'd3});
      tbl.push_back('{32'hFE112E23, 5'd5,  64'hFFFFFFFC, 3'd2, 64'hFFFFFFFFFFFFFFFC, 3'd2});
      tbl.push_back('{32'h0080006F, 5'd6,  64'h8,        3'd5, 64'h8,                3'd5});
      tbl.push_back('{32'h00008067, 5'd7,  64'h0,        3'd1, 64'h0,                3'd1});
      tbl.push_back('{32'h03F09093, 5'd8,  64'h1F,       3'd6, 64'h3F,               3'd6});
      tbl.push_back('{32'hFFF0009B, 5'd9,  64'h0,        3'd0, 64'hFFFFFFFFFFFFFFFF, 3'd1});
      tbl.push_back('{32'h0010909B, 5'd10, 64'h0,        3'd0, 64'h1,                3'd6});
`ifdef IMM_GEN_UTYPE_EN
      tbl.push_back('{32'h12345037, 5'd11, 64'h12345000, 3'd4, 64'h12345000,         3'd4});
      tbl.push_back('{32'hFFFFF017, 5'd12, 64'hFFFFF000, 3'd4, 64'hFFFFFFFFFFFFF000, 3'd4});
`else
      tbl.push_back('{32'h12345037, 5'd11, 64'h0,        3'd0, 64'h0,                3'd0});
      tbl.push_back('{32'hFFFFF017, 5'd12, 64'h0,        3'd0, 64'h0,                3'd0});
`endif
      tbl.push_back('{32'h00000033, 5'd13, 64'h0,        3'd0, 64'h0,                3'd0});
      tbl.push_back('{32'h80002003, 5'd14, 64'hFFFFF800, 3'd1, 64'hFFFFFFFFFFFFF800, 3'd1});
      tbl.push_back('{32'h7FF00093, 5'd15, 64'h7FF,      3'd1, 64'h7FF,              3'd1});

      step(); step();
      e = '{32'h0, 5'd0, 64'h0, 3'd0, 64'h0, 3'd0};
      chk_hs("reset", 1'b0, 1'b1);
      chk_data("reset", e);
      chk_cnt("reset");
      rst = 1'b0;

      // table vectors back to back at full throughput
      in_valid = 1'b1;
      foreach (tbl[i]) begin
         inst_code = tbl[i].inst;
         in_tag    = tbl[i].tag;
         bump(tbl[i].fmt32, tbl[i].fmt64);
         step();
         chk_hs($sformatf("tbl%0d", i), 1'b1, 1'b1);
         chk_data($sformatf("tbl%0d", i), tbl[i]);
         chk_cnt($sformatf("tbl%0d", i));
      end
      in_valid = 1'b0;
      step();
      chk_hs("tbl drain", 1'b0, 1'b1);

      // back-pressure: two results stall, third offer refused, then in-order release
      out_ready = 1'b0; in_valid = 1'b1; inst_code = 32'hFFF00093;
      e = tbl[0];
      in_tag = 5'd1; step();
      e.tag = 5'd1; chk_hs("bp one", 1'b1, 1'b1); chk_data("bp one", e);
      in_tag = 5'd2; step();
      chk_hs("bp full", 1'b1, 1'b0); chk_data("bp full", e);
      in_tag = 5'd3; step();
      chk_hs("bp hold", 1'b1, 1'b0); chk_data("bp hold", e);
      in_valid = 1'b0; out_ready = 1'b1; step();
      e.tag = 5'd2; chk_hs("bp rel2", 1'b1, 1'b1); chk_data("bp rel2", e);
      step();
      chk_hs("bp empty", 1'b0, 1'b1);

      // reset while full clears both entries and the counter
      out_ready = 1'b0; in_valid = 1'b1; inst_code = 32'h00000033;
      in_tag = 5'd5; step(); in_tag = 5'd6; step();
      exp_cnt32 += 2; exp_cnt64 = (exp_cnt64 + 2 > CNT64_MAX) ? CNT64_MAX : exp_cnt64 + 2;
      chk_hs("pre-rst", 1'b1, 1'b0); chk_cnt("pre-rst");
      rst = 1'b1; flush = 1'b1; step();
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
      exp_cnt32 = 0; exp_cnt64 = 0;
      chk_hs("rst full", 1'b0, 1'b1); chk_cnt("rst full");

      // flush while full keeps the counter
      in_valid = 1'b1; step(); step();
      exp_cnt32 = 2; exp_cnt64 = 2;
      chk_hs("pre-flush", 1'b1, 1'b0);
      flush = 1'b1; step();
      flush = 1'b0; in_valid = 1'b0;
      chk_hs("flush full", 1'b0, 1'b1); chk_cnt("flush full");

      // flush from one entry with a discarded, uncounted illegal offer
      in_valid = 1'b1; step();
      exp_cnt32 = 3; exp_cnt64 = 3;
      flush = 1'b1; step();
      flush = 1'b0; in_valid = 1'b0;
      chk_hs("flush one", 1'b0, 1'b1); chk_cnt("flush one");
      step();
      chk_hs("flush idle", 1'b0, 1'b1); chk_cnt("flush idle");

      // randomized traffic against a two-deep FIFO model
      model_q.delete();
      for (int c = 0; c < 1500; c++) begin
         chk_hs("rnd", model_q.size() > 0, model_q.size() < 2);
         if (model_q.size() > 0) chk_data("rnd", model_q[0]);
         chk_cnt("rnd");

         r         = $urandom();
         in_valid  = r[0] | r[1];
         out_ready = r[2] | (r[3] & r[4]);
         flush     = (r[10:5] == 6'd0);
         in_tag    = r[15:11];
         inst_code = rand_inst();

         if (flush) begin
            model_q.delete();
         end else begin
            bit acc;
            acc = in_valid && (model_q.size() < 2);
            if (model_q.size() > 0 && out_ready) void'(model_q.pop_front());
            if (acc) begin
               e.inst = inst_code;
               e.tag  = in_tag;
               ref_decode(inst_code, 1'b0, e.imm32, e.fmt32);
               ref_decode(inst_code, 1'b1, e.imm64, e.fmt64);
               bump(e.fmt32, e.fmt64);
               model_q.push_back(e);
            end
         end
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
